demux_1x8: RTL and testbench
============================

Name: demux_1x8

Overview:
- Serial-to-parallel counterpart of the 8:1 output mux: collects a stream of single bits and rebuilds a WIDTH-bit word.
- Bit k of each word lands in word_o[k]; the first accepted bit is bit 0. This mirrors the mux's sel_i = 0..7 ordering.
- Valid/ready handshake on both sides. Double-buffered: one word can be held at the output while the next is being assembled.
- Sits at the receive end of any serialised 8-bit path in the design.

Parameters:
- WIDTH, 8, word width in bits; must be a power of 2 and >= 2.
- IDX_W, $clog2(WIDTH), width of the bit index/count (derived, not overridable).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- clear_i  input  1  synchronous abort of the partially assembled word.
- bit_i  input  1  serial data bit.
- bit_valid_i  input  1  bit_i is valid this cycle.
- bit_ready_o  output  1  block can accept bit_i this cycle (combinational).
- word_o  output  WIDTH  assembled word (registered).
- word_valid_o  output  1  word_o holds a complete, unconsumed word (registered).
- word_ready_i  input  1  downstream consumes word_o this cycle.
- count_o  output  IDX_W  number of bits collected in the current partial word (registered).

Behaviour:
- State:
  - asm_q[WIDTH-1:0]: assembly register.
  - idx_q[IDX_W-1:0]: next bit position.
  - word_o / word_valid_o: output register.
  - count_o = idx_q.
- Reset (rst_i high at clock edge): asm_q=0, idx_q=0, word_o=0, word_valid_o=0, count_o=0. bit_ready_o=0 while rst_i is high. rst_i overrides every other input.
- Output slot frees this cycle: out_free = !word_valid_o || word_ready_i.
- bit_ready_o = !rst_i && !clear_i && ((idx_q != WIDTH-1) || out_free).
  - Partial bits are always accepted.
  - Only the completing bit stalls while a pending word is unconsumed.
- Bit accept (bit_valid_i && bit_ready_o):
  - asm_q[idx_q] <= bit_i.
  - If idx_q != WIDTH-1: idx_q <= idx_q+1.
  - If idx_q == WIDTH-1:
    - word_o <= {bit_i, asm_q[WIDTH-2:0]}
    - word_valid_o <= 1
    - idx_q <= 0 (wrap)
    - asm_q <= 0
- Latency: completing bit accepted at edge N -> word_valid_o=1 and word_o valid from edge N (visible cycle N+1). Zero bubble between consecutive words.
- Word consume (word_valid_o && word_ready_i with no completion this cycle): word_valid_o <= 0. word_o retains its last value.
- Simultaneous consume + completion: word_o loads the new word and word_valid_o stays 1. No word is lost or duplicated.
- word_ready_i while word_valid_o=0: ignored.
- clear_i (no reset):
  - idx_q <= 0, asm_q <= 0.
  - The bit offered that cycle is not accepted (bit_ready_o=0).
  - word_o / word_valid_o are unaffected, and a consume in the same cycle still completes.
- bit_valid_i low: no state change on the input side. Bits may arrive with arbitrary gaps.
- word_o never shows partially assembled data.

Test Plan:
- Reset then stream bits 1,0,1,1,0,0,1,0 back-to-back with word_ready_i=1 -> after the 8th bit edge: word_valid_o=1, word_o=8'h4D; count_o goes 0..7 then returns to 0; word_valid_o drops the next cycle.
- Two words back-to-back (0x4D then 0xA5 = bits 1,0,1,0,0,1,0,1) with word_ready_i=0:
  - bits 1-7 of the second word are accepted, and bit_ready_o=0 when count_o=7.
  - Raise word_ready_i -> 8th bit accepted the same cycle; 0x4D consumed, word_o=8'hA5, word_valid_o stays 1.
- Feed 5 bits (1,1,1,1,1), assert clear_i for 1 cycle with bit_valid_i=1 -> bit not accepted; count_o=0. Then 8 bits 0,0,0,0,0,0,0,1 -> word_o=8'h80.
- Assert clear_i while word 0x4D is pending, with word_ready_i=0 -> word_o=8'h4D and word_valid_o=1 are retained; count_o=0.
- Assert rst_i mid-word (count_o=3) while a word is pending -> next cycle word_valid_o=0, word_o=0, count_o=0, bit_ready_o=0 during reset. Then 8 bits of 0xFF -> word_o=8'hFF.
- Random gaps in bit_valid_i (e.g. valid every 3rd cycle) for 0x3C -> word_o=8'h3C, with no extra or missing bits.

Source files
------------

// File: rtl/demux_1x8.sv
// demux_1x8: serial-to-parallel word assembler.
// Collects single bits (first accepted bit -> word_o[0]) into a WIDTH-bit word.
// The output register holds one finished word while the next one is assembled.
// Only the completing bit stalls when the finished word has not been consumed.

module demux_1x8 #(
    parameter int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             bit_i,
    input  logic             bit_valid_i,
    output logic             bit_ready_o,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic [IDX_W-1:0] count_o
);

    // Assembly side state
    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] asm_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    // Output side state
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;
    logic             word_valid_q;
    logic             word_valid_d;

    // Handshake helpers
    logic out_free_s;
    logic last_s;
    logic accept_s;
    logic complete_s;

    // The output slot is free if it is empty or being consumed this cycle.
    assign out_free_s  = !word_valid_q || word_ready_i;
    assign last_s      = (idx_q == IDX_W'(WIDTH - 1));
    assign bit_ready_o = !rst_i && !clear_i && (!last_s || out_free_s);
    assign accept_s    = bit_valid_i && bit_ready_o;
    assign complete_s  = accept_s && last_s;

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;
    assign count_o      = idx_q;

    // Next-state for the assembly register and bit index.
    always_comb begin
        asm_d = asm_q;
        idx_d = idx_q;
        if (clear_i) begin
            // Abort the partial word; the offered bit is refused via bit_ready_o.
            asm_d = '0;
            idx_d = '0;
        end else if (accept_s) begin
            if (last_s) begin
                // Completed word moves to the output; start a fresh word.
                asm_d = '0;
                idx_d = '0;
            end else begin
                asm_d[idx_q] = bit_i;
                idx_d        = idx_q + IDX_W'(1);
            end
        end else begin
            asm_d = asm_q;
            idx_d = idx_q;
        end
    end

    // Next-state for the output word register and its valid flag.
    always_comb begin
        word_d       = word_q;
        word_valid_d = word_valid_q;
        if (complete_s) begin
            // A completion overrides a same-cycle consume: new word replaces old.
            word_d       = {bit_i, asm_q[WIDTH-2:0]};
            word_valid_d = 1'b1;
        end else if (word_valid_q && word_ready_i) begin
            // Consume: data stays visible, only the valid flag drops.
            word_valid_d = 1'b0;
        end else begin
            word_valid_d = word_valid_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            asm_q        <= '0;
            idx_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

endmodule

// File: tb/tb_demux_1x8.sv
// Testbench for demux_1x8: directed bit streams, scoreboard of expected words
// checked by an independent monitor on every output handshake.

module tb_demux_1x8;

    logic       clk_i;
    logic       rst_i;
    logic       clear_i;
    logic       bit_i;
    logic       bit_valid_i;
    logic       bit_ready_o;
    logic [7:0] word_o;
    logic       word_valid_o;
    logic       word_ready_i;
    logic [2:0] count_o;

    int total;
    int bad;

    logic [7:0] exp_q[$];

    demux_1x8 #(.WIDTH(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .bit_i        (bit_i),
        .bit_valid_i  (bit_valid_i),
        .bit_ready_o  (bit_ready_o),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .count_o      (count_o)
    );

    // 10-unit clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: on every output handshake pop the oldest expected word and compare.
    always @(negedge clk_i) begin
        if (!rst_i && word_valid_o === 1'b1 && word_ready_i === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL word_unexpected: got 0x%0h expected no word", word_o);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (word_o !== e) begin
                    bad++;
                    $display("FAIL word_data: got 0x%0h expected 0x%0h", word_o, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Offer one bit, wait (bounded) for bit_ready_o, return just after the accepting edge.
    task automatic send_bit(input logic b);
        int n;
        bit_valid_i = 1'b1;
        bit_i       = b;
        #1;
        n = 0;
        while (bit_ready_o !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (bit_ready_o !== 1'b1) begin
            chk("bit_ready_wait", {31'd0, bit_ready_o}, 32'd1);
        end
        step();
    endtask

    // Send a full word LSB first; gap idle cycles between bits; expected word
    // is pushed when its final bit is offered.
    task automatic send_word(input logic [7:0] w, input int gap);
        for (int i = 0; i < 8; i++) begin
            chk("count_before_bit", {29'd0, count_o}, i);
            if (i == 7) exp_q.push_back(w);
            send_bit(w[i]);
            if (gap > 0 && i < 7) begin
                bit_valid_i = 1'b0;
                bit_i       = ~w[i];
                for (int g = 0; g < gap; g++) begin
                    step();
                    chk("count_in_gap", {29'd0, count_o}, i + 1);
                end
            end
        end
        bit_valid_i = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        total        = 0;
        bad          = 0;
        rst_i        = 1'b1;
        clear_i      = 1'b0;
        bit_i        = 1'b0;
        bit_valid_i  = 1'b0;
        word_ready_i = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_word_valid", {31'd0, word_valid_o}, 32'd0);
        chk("rst_word", {24'd0, word_o}, 32'd0);
        chk("rst_count", {29'd0, count_o}, 32'd0);
        chk("rst_bit_ready", {31'd0, bit_ready_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        chk("bit_ready_idle", {31'd0, bit_ready_o}, 32'd1);

        // Test 1: single word 0x4D, downstream always ready
        word_ready_i = 1'b1;
        send_word(8'h4D, 0);
        chk("t1_valid", {31'd0, word_valid_o}, 32'd1);
        chk("t1_word", {24'd0, word_o}, 32'h4D);
        chk("t1_count_wrap", {29'd0, count_o}, 32'd0);
        step();
        chk("t1_valid_drop", {31'd0, word_valid_o}, 32'd0);
        chk("t1_word_kept", {24'd0, word_o}, 32'h4D);

        // Test 2: two words back-to-back with downstream stalled
        word_ready_i = 1'b0;
        send_word(8'h4D, 0);
        w = 8'hA5;
        for (int i = 0; i < 7; i++) begin
            send_bit(w[i]);
        end
        bit_valid_i = 1'b1;
        bit_i       = w[7];
        #1;
        chk("t2_count7", {29'd0, count_o}, 32'd7);
        chk("t2_stall", {31'd0, bit_ready_o}, 32'd0);
        chk("t2_pending", {24'd0, word_o}, 32'h4D);
        step();
        step();
        chk("t2_still_stall", {31'd0, bit_ready_o}, 32'd0);
        chk("t2_count_hold", {29'd0, count_o}, 32'd7);
        word_ready_i = 1'b1;
        exp_q.push_back(8'hA5);
        #1;
        chk("t2_ready_on_consume", {31'd0, bit_ready_o}, 32'd1);
        step();
        bit_valid_i = 1'b0;
        chk("t2_word", {24'd0, word_o}, 32'hA5);
        chk("t2_valid_stays", {31'd0, word_valid_o}, 32'd1);
        chk("t2_count_wrap", {29'd0, count_o}, 32'd0);
        step();
        chk("t2_valid_drop", {31'd0, word_valid_o}, 32'd0);

        // Test 3: clear aborts a partial word, offered bit is refused
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("t3_count5", {29'd0, count_o}, 32'd5);
        clear_i     = 1'b1;
        bit_valid_i = 1'b1;
        bit_i       = 1'b1;
        #1;
        chk("t3_clear_refuse", {31'd0, bit_ready_o}, 32'd0);
        step();
        clear_i     = 1'b0;
        bit_valid_i = 1'b0;
        chk("t3_count_cleared", {29'd0, count_o}, 32'd0);
        send_word(8'h80, 0);
        chk("t3_word", {24'd0, word_o}, 32'h80);
        step();

        // Test 4: clear with a pending word leaves the output untouched
        word_ready_i = 1'b0;
        send_word(8'h4D, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        bit_valid_i = 1'b0;
        chk("t4_count3", {29'd0, count_o}, 32'd3);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("t4_word_kept", {24'd0, word_o}, 32'h4D);
        chk("t4_valid_kept", {31'd0, word_valid_o}, 32'd1);
        chk("t4_count_cleared", {29'd0, count_o}, 32'd0);

        // Test 5: reset mid-word discards the pending word and the partial word
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        bit_valid_i = 1'b0;
        chk("t5_count3", {29'd0, count_o}, 32'd3);
        rst_i = 1'b1;
        exp_q.delete();
        #1;
        chk("t5_ready_in_rst", {31'd0, bit_ready_o}, 32'd0);
        step();
        chk("t5_valid", {31'd0, word_valid_o}, 32'd0);
        chk("t5_word", {24'd0, word_o}, 32'd0);
        chk("t5_count", {29'd0, count_o}, 32'd0);
        chk("t5_ready_still_rst", {31'd0, bit_ready_o}, 32'd0);
        rst_i        = 1'b0;
        word_ready_i = 1'b1;
        send_word(8'hFF, 0);
        chk("t5_word_ff", {24'd0, word_o}, 32'hFF);
        step();

        // Test 6: sparse bits, one every third cycle
        send_word(8'h3C, 2);
        chk("t6_word", {24'd0, word_o}, 32'h3C);
        chk("t6_count_wrap", {29'd0, count_o}, 32'd0);
        step();
        step();
        chk("t6_valid_drop", {31'd0, word_valid_o}, 32'd0);

        // Every expected word must have been delivered
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
